quad_input_debounce: RTL



---
 rtl/quad_input_pkg.sv | 16 +
 rtl/quad_input_debounce_channel.sv | 59 +++++
 rtl/quad_input_debounce.sv | 57 +++++
 3 files changed

// File: rtl/quad_input_pkg.sv
// Shared constants for the quadrature input debouncer: default timing
// parameters and the prescaler counter width helper.
package quad_input_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TICK_DIV    = 256;
  localparam int DEF_HIST_LEN    = 8;

  // A divide-by-1 prescaler still needs a one-bit counter to stay legal.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_TICK_DIV);

endpackage

// File: rtl/quad_input_debounce_channel.sv
// One debounced input bit: synchroniser, sample history and the clean/changed
// output flops. Samples are taken only on the shared prescaler tick.
module debounce_channel
  import quad_input_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HIST_LEN    = DEF_HIST_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic clean,
  output logic changed
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [HIST_LEN-2:0]    hist_q, hist_d;
  logic                   clean_q, clean_d;
  logic                   changed_q, changed_d;
  logic [HIST_LEN-1:0]    nh;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], raw};
    nh        = {hist_q, sync_q[SYNC_STAGES-1]};
    hist_d    = hist_q;
    clean_d   = clean_q;
    changed_d = 1'b0;
    if (tick) begin
      hist_d = nh[HIST_LEN-2:0];
      // Only a full window of agreeing samples that differs from clean toggles it.
      if ((&nh) && !clean_q) begin
        clean_d   = 1'b1;
        changed_d = 1'b1;
      end else if (!(|nh) && clean_q) begin
        clean_d   = 1'b0;
        changed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      hist_q    <= '0;
      clean_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
    end
  end

  assign clean   = clean_q;
  assign changed = changed_q;

endmodule

// File: rtl/quad_input_debounce.sv
// Debounces the raw a/b pins of one rotary encoder. A shared prescaler
// produces the sample tick; each pin gets its own debounce_channel.
module quad_input_debounce
  import quad_input_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int HIST_LEN    = DEF_HIST_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] changed,
  output logic                tick
);

  localparam int             CW       = cnt_width(TICK_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick is registered, so it is high in the cycle after the count hits its last value.
  always_comb begin
    tick_d = (cnt_q == CNT_LAST);
    cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .HIST_LEN   (HIST_LEN)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw[i]),
      .tick   (tick_q),
      .clean  (clean[i]),
      .changed(changed[i])
    );
  end

endmodule
